tx_mac_arbiter: RTL and testbench
=================================

TX_MAC_ARBITER -- requirements
Module: tx_mac_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum cycles a grant is held waiting for the source's tx_start.
REQ-002 Parameter CNT_W, default 32: width of the per-source frame counters.
REQ-003 Port clk, input, 1 bit: single clock for all logic.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports s0_req and s1_req, input, 1 bit each: the source has a complete frame committed and ready to send.
REQ-006 Ports s0_gnt and s1_gnt, output, 1 bit each: the source owns the MAC TX path.
REQ-007 Ports sN_tx_start, sN_tx_data[63:0], sN_tx_data_valid[7:0] and sN_tx_underrun, inputs: the per-source MAC TX request signals.
REQ-008 Port sN_tx_ack, output, 1 bit: the MAC's ack, routed to the granted source only.
REQ-009 Ports tx_start, tx_data[63:0], tx_data_valid[7:0] and tx_underrun, outputs: drive the MAC TX port.
REQ-010 Port tx_ack, input, 1 bit: MAC ack.
REQ-011 Ports s0_frames and s1_frames, output, CNT_W bits each: number of completed frames per source.
REQ-012 Port timeouts, output, 16 bits: number of revoked grants (saturating).

Function
REQ-013 The datapath mux SHALL be purely combinational: tx_* equals the granted source's signals, and all tx_* are 0 when no source is granted.
REQ-014 sN_tx_ack SHALL equal tx_ack AND sN_gnt, with zero added latency.
REQ-015 The FSM SHALL have four states: ARB, GRANTED, IN_FRAME and RELEASE.
REQ-016 In ARB, if any req is high, the arbiter SHALL grant one source, registered, entering GRANTED on the next cycle.
REQ-017 In ARB, when both reqs are high, the source not served last SHALL win (round-robin); after reset, s0 wins.
REQ-018 In GRANTED, sN_gnt SHALL be held high and a wait counter SHALL increment each cycle.
REQ-019 In GRANTED, on the granted source's tx_start the FSM SHALL enter IN_FRAME.
REQ-020 In GRANTED, when the wait counter reaches TIMEOUT_CYC-1 without tx_start, the FSM SHALL enter RELEASE and timeouts SHALL increment.
REQ-021 In IN_FRAME, a data_seen flag SHALL be set on the first cycle with tx_data_valid != 0.
REQ-022 In IN_FRAME, end-of-frame SHALL be detected as data_seen AND tx_data_valid != 8'hFF, including 8'h00.
REQ-023 On end-of-frame, the granted sN_frames SHALL increment and the FSM SHALL enter RELEASE.
REQ-024 In IN_FRAME, tx_underrun from the granted source SHALL pass to the MAC in the same cycle and the FSM SHALL enter RELEASE; the frame counter SHALL NOT increment.
REQ-025 In RELEASE, gnt SHALL be low for exactly one cycle, last-served SHALL update to the granted source, and the FSM SHALL return to ARB.
REQ-026 A tx_start from a non-granted source SHALL be ignored and never reach the MAC.
REQ-027 A req deasserted while GRANTED or IN_FRAME SHALL NOT revoke the grant; only end-of-frame, underrun or timeout end ownership.
REQ-028 Frame counters SHALL wrap modulo 2^CNT_W.
REQ-029 The timeout counter SHALL saturate at 16'hFFFF.
REQ-030 A tx_start and end-of-frame arriving in the same cycle is illegal and SHALL be treated as tx_start only.
REQ-031 Minimum grant-to-grant spacing SHALL be 1 cycle of RELEASE plus 1 cycle of ARB.

Reset
REQ-032 While reset is high, the FSM SHALL be in ARB, all gnt low, all tx_* outputs 0, counters 0, last-served = s1 (so s0 wins first), and data_seen = 0.
REQ-033 Reset asserted mid-frame SHALL drop the grant immediately and asynchronously; no underrun is generated.
REQ-034 After reset deasserts, arbitration SHALL resume on the first clock edge.

Structure
REQ-035 FSM state encodings and the default TIMEOUT_CYC SHALL live in the shared TX defines file, next to the existing TX state constants.
REQ-036 A single sub-module, rr_arb2 (two-way round-robin pick with a last-served register), is natural; everything else stays flat.

Verification
REQ-037 s0_req only; s0 sends start, 4x valid FF, valid 0F -> s0_gnt high through the frame, MAC sees identical words, s0_frames = 1, gnt low for 1 cycle.
REQ-038 s0_req and s1_req both held, each sending a 3-qword frame, 6 frames total -> grants alternate s0, s1, s0, s1, s0, s1; each counter = 3.
REQ-039 s1 granted and never asserts start, TIMEOUT_CYC = 8 -> gnt drops after 8 cycles, timeouts = 1, s0 granted next if requesting.
REQ-040 s0 mid-frame pulses underrun -> tx_underrun high in the same cycle, s0_frames unchanged, grant released.
REQ-041 s1 asserts tx_start while s0 is in frame -> MAC tx_start is not asserted for s1, s1_tx_ack stays 0.
REQ-042 reset asserted during IN_FRAME, then released -> all outputs 0 immediately; first grant after release goes to s0.

Source files
------------

// File: rtl/tx_mac_arbiter_pkg.sv
// Shared TX definitions: arbiter state encodings, default grant timeout and the
// per-source MAC TX bundle used by the datapath mux.
package tx_mac_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_GRANTED  = 2'd1,
        ST_IN_FRAME = 2'd2,
        ST_RELEASE  = 2'd3
    } tx_arb_state_e;

    localparam int          TX_TIMEOUT_CYC_DEFAULT = 64;
    localparam logic [7:0]  TX_VALID_FULL          = 8'hFF;
    localparam logic [15:0] TX_TIMEOUT_MAX         = 16'hFFFF;

    typedef struct packed {
        logic        start;
        logic [63:0] data;
        logic [7:0]  data_valid;
        logic        underrun;
    } tx_bus_t;

    // A partial (or empty) word after payload has started closes the frame.
    function automatic logic tx_frame_end(input logic data_seen, input logic [7:0] data_valid);
        return data_seen && (data_valid != TX_VALID_FULL);
    endfunction

endpackage

// File: rtl/tx_mac_arbiter_rr_arb2.sv
// Two-way round-robin pick; the last-served register is updated when a grant
// is released, so the other source wins the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       pick,
    output logic       valid
);

    logic last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        valid = |req;
        pick  = req[1] & (~req[0] | ~last_q);
    end

endmodule

// File: rtl/tx_mac_arbiter.sv
// Two-source MAC TX arbiter: round-robin grant, combinational datapath mux,
// per-source frame counters and a saturating revoked-grant counter.
//
// state       | meaning
// ST_ARB      | no owner; grant a requesting source at the next edge
// ST_GRANTED  | source owns the path, waiting for its tx_start (timeout armed)
// ST_IN_FRAME | frame in flight; ends on end-of-frame or underrun
// ST_RELEASE  | one idle cycle with grant low, last-served updated
module tx_mac_arbiter
    import tx_mac_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TX_TIMEOUT_CYC_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             s0_req,
    output logic             s0_gnt,
    input  logic             s0_tx_start,
    input  logic [63:0]      s0_tx_data,
    input  logic [7:0]       s0_tx_data_valid,
    input  logic             s0_tx_underrun,
    output logic             s0_tx_ack,

    input  logic             s1_req,
    output logic             s1_gnt,
    input  logic             s1_tx_start,
    input  logic [63:0]      s1_tx_data,
    input  logic [7:0]       s1_tx_data_valid,
    input  logic             s1_tx_underrun,
    output logic             s1_tx_ack,

    output logic             tx_start,
    output logic [63:0]      tx_data,
    output logic [7:0]       tx_data_valid,
    output logic             tx_underrun,
    input  logic             tx_ack,

    output logic [CNT_W-1:0] s0_frames,
    output logic [CNT_W-1:0] s1_frames,
    output logic [15:0]      timeouts
);

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYC - 1);

    tx_arb_state_e     state;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              sel_q;
    logic              data_seen;
    logic [WAIT_W-1:0] wait_cnt;

    logic              arb_pick;
    logic              arb_valid;
    tx_bus_t           src0;
    tx_bus_t           src1;
    tx_bus_t           mux;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    ({s1_req, s0_req}),
        .update (state == ST_RELEASE),
        .served (sel_q),
        .pick   (arb_pick),
        .valid  (arb_valid)
    );

    always_comb begin
        src0 = '{start: s0_tx_start, data: s0_tx_data,
                 data_valid: s0_tx_data_valid, underrun: s0_tx_underrun};
        src1 = '{start: s1_tx_start, data: s1_tx_data,
                 data_valid: s1_tx_data_valid, underrun: s1_tx_underrun};
        mux  = '0;
        if (gnt0_q) begin
            mux = src0;
        end else if (gnt1_q) begin
            mux = src1;
        end
    end

    assign tx_start      = mux.start;
    assign tx_data       = mux.data;
    assign tx_data_valid = mux.data_valid;
    assign tx_underrun   = mux.underrun;

    assign s0_gnt    = gnt0_q;
    assign s1_gnt    = gnt1_q;
    assign s0_tx_ack = tx_ack & gnt0_q;
    assign s1_tx_ack = tx_ack & gnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ARB;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            sel_q     <= 1'b0;
            data_seen <= 1'b0;
            wait_cnt  <= '0;
            s0_frames <= '0;
            s1_frames <= '0;
            timeouts  <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (arb_valid) begin
                        state     <= ST_GRANTED;
                        sel_q     <= arb_pick;
                        gnt0_q    <= ~arb_pick;
                        gnt1_q    <= arb_pick;
                        wait_cnt  <= WAIT_LOAD;
                        data_seen <= 1'b0;
                    end
                end
                ST_GRANTED: begin
                    if (mux.start) begin
                        state     <= ST_IN_FRAME;
                        data_seen <= 1'b0;
                    end else if (wait_cnt == '0) begin
                        state  <= ST_RELEASE;
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                        if (timeouts != TX_TIMEOUT_MAX) begin
                            timeouts <= timeouts + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_IN_FRAME: begin
                    // A repeated start masks any coincident end-of-frame.
                    if (mux.underrun) begin
                        state  <= ST_RELEASE;
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                    end else if (!mux.start && tx_frame_end(data_seen, mux.data_valid)) begin
                        state  <= ST_RELEASE;
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                        if (sel_q) begin
                            s1_frames <= s1_frames + CNT_W'(1);
                        end else begin
                            s0_frames <= s0_frames + CNT_W'(1);
                        end
                    end else if (mux.data_valid != 8'h00) begin
                        data_seen <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_ARB;
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_mac_arbiter.sv
// Directed bench for tx_mac_arbiter: a per-cycle vector table for a single
// frame plus hand sequences for underrun, timeout, reset and round-robin.
module tb_tx_mac_arbiter;

    logic        clk;
    logic        reset;
    logic        s0_req, s1_req;
    logic        s0_gnt, s1_gnt;
    logic        s0_tx_start, s1_tx_start;
    logic [63:0] s0_tx_data, s1_tx_data;
    logic [7:0]  s0_tx_data_valid, s1_tx_data_valid;
    logic        s0_tx_underrun, s1_tx_underrun;
    logic        s0_tx_ack, s1_tx_ack;
    logic        tx_start;
    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_underrun;
    logic        tx_ack;
    logic [1:0]  s0_frames, s1_frames;
    logic [15:0] timeouts;

    int checks   = 0;
    int failures = 0;

    tx_mac_arbiter #(.TIMEOUT_CYC(8), .CNT_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .s0_req           (s0_req),
        .s0_gnt           (s0_gnt),
        .s0_tx_start      (s0_tx_start),
        .s0_tx_data       (s0_tx_data),
        .s0_tx_data_valid (s0_tx_data_valid),
        .s0_tx_underrun   (s0_tx_underrun),
        .s0_tx_ack        (s0_tx_ack),
        .s1_req           (s1_req),
        .s1_gnt           (s1_gnt),
        .s1_tx_start      (s1_tx_start),
        .s1_tx_data       (s1_tx_data),
        .s1_tx_data_valid (s1_tx_data_valid),
        .s1_tx_underrun   (s1_tx_underrun),
        .s1_tx_ack        (s1_tx_ack),
        .tx_start         (tx_start),
        .tx_data          (tx_data),
        .tx_data_valid    (tx_data_valid),
        .tx_underrun      (tx_underrun),
        .tx_ack           (tx_ack),
        .s0_frames        (s0_frames),
        .s1_frames        (s1_frames),
        .timeouts         (timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s0_req;
        logic        s0_start;
        logic [7:0]  s0_valid;
        logic [63:0] s0_data;
        logic        s1_start;
        logic        ack_in;
        logic        e_g0;
        logic        e_start;
        logic [7:0]  e_valid;
        logic [63:0] e_data;
        logic        e_a0;
        logic        e_a1;
        logic [1:0]  e_f0;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_src(input int src, input logic st, input logic [7:0] v,
                             input logic [63:0] d, input logic ur);
        if (src == 0) begin
            s0_tx_start = st; s0_tx_data_valid = v; s0_tx_data = d; s0_tx_underrun = ur;
        end else begin
            s1_tx_start = st; s1_tx_data_valid = v; s1_tx_data = d; s1_tx_underrun = ur;
        end
    endtask

    task automatic wait_grant(output int who, output int waited);
        waited = 0;
        who    = -1;
        while (!(s0_gnt || s1_gnt) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (s0_gnt) who = 0;
        else if (s1_gnt) who = 1;
        else begin
            checks++;
            failures++;
            $display("FAIL wait_grant: actual=no grant after %0d cycles required=grant", waited);
        end
    endtask

    // Called at the negedge of the first granted cycle; returns at the
    // negedge of the release cycle.
    task automatic send_frame(input int src, input int nq);
        logic [63:0] d;
        drive_src(src, 1'b1, 8'h00, 64'hF000, 1'b0);
        @(negedge clk);
        for (int q = 0; q < nq; q++) begin
            d = {32'hD0D0_0000, 16'(src), 16'(q)};
            drive_src(src, 1'b0, (q == nq - 1) ? 8'h0F : 8'hFF, d, 1'b0);
            #1;
            check("frame_word", 80'(tx_data), 80'(d));
            @(negedge clk);
        end
        drive_src(src, 1'b0, 8'h00, 64'h0, 1'b0);
    endtask

    int who, waited, hi;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h00, 64'hD0, 1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 64'h0,  1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 64'hD1, 1'b0, 1'b0,  1'b1, 1'b1, 8'h00, 64'hD1, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 64'hD2, 1'b1, 1'b1,  1'b1, 1'b0, 8'hFF, 64'hD2, 1'b1, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 1'b0, 8'hFF, 64'hD3, 1'b0, 1'b0,  1'b1, 1'b0, 8'hFF, 64'hD3, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 64'hD4, 1'b1, 1'b1,  1'b1, 1'b0, 8'hFF, 64'hD4, 1'b1, 1'b0, 2'd0};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 64'hD5, 1'b0, 1'b0,  1'b1, 1'b0, 8'hFF, 64'hD5, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{1'b0, 1'b0, 8'h0F, 64'hD6, 1'b0, 1'b1,  1'b1, 1'b0, 8'h0F, 64'hD6, 1'b1, 1'b0, 2'd0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 64'h0,  1'b0, 1'b1,  1'b0, 1'b0, 8'h00, 64'h0,  1'b0, 1'b0, 2'd1};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 64'h0,  1'b0, 1'b0,  1'b0, 1'b0, 8'h00, 64'h0,  1'b0, 1'b0, 2'd1};

        reset = 1'b1;
        s0_req = 1'b1; s1_req = 1'b0; tx_ack = 1'b1;
        drive_src(0, 1'b1, 8'hFF, 64'hDEAD, 1'b1);
        drive_src(1, 1'b0, 8'h3C, 64'h5555_5555_5555_5555, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_outputs", 80'({s0_gnt, s1_gnt, tx_start, tx_data_valid, tx_data,
                                    tx_underrun, s0_tx_ack, s1_tx_ack}), 80'(0));
        check("reset_counters", 80'({s0_frames, s1_frames, timeouts}), 80'(0));
        s0_req = 1'b0; tx_ack = 1'b0;
        drive_src(0, 1'b0, 8'h00, 64'h0, 1'b0);
        reset = 1'b0;

        // Single s0 frame, s1 start ignored mid-frame, req dropped mid-frame.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            s0_req = vecs[i].s0_req;
            drive_src(0, vecs[i].s0_start, vecs[i].s0_valid, vecs[i].s0_data, 1'b0);
            s1_tx_start = vecs[i].s1_start;
            tx_ack = vecs[i].ack_in;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {s0_gnt, s1_gnt, tx_start, tx_data_valid, tx_data, tx_underrun,
                   s0_tx_ack, s1_tx_ack, s0_frames},
                  {vecs[i].e_g0, 1'b0, vecs[i].e_start, vecs[i].e_valid, vecs[i].e_data,
                   1'b0, vecs[i].e_a0, vecs[i].e_a1, vecs[i].e_f0});
        end
        drive_src(1, 1'b0, 8'h00, 64'h0, 1'b0);
        tx_ack = 1'b0;

        // Underrun mid-frame: passes through, releases, no frame counted.
        s0_req = 1'b1;
        wait_grant(who, waited);
        check("ur_grant", 80'(who), 80'(0));
        drive_src(0, 1'b1, 8'h00, 64'h0, 1'b0);
        @(negedge clk);
        drive_src(0, 1'b0, 8'hFF, 64'h11, 1'b0);
        @(negedge clk);
        drive_src(0, 1'b0, 8'hFF, 64'h12, 1'b1);
        #1;
        check("ur_passthrough", 80'(tx_underrun), 80'(1));
        @(negedge clk);
        drive_src(0, 1'b0, 8'h00, 64'h0, 1'b0);
        s0_req = 1'b0;
        check("ur_released", 80'({s0_gnt, s1_gnt}), 80'(0));
        check("ur_frames", 80'(s0_frames), 80'(1));

        // Timeout: s1 granted, never starts, grant held exactly 8 cycles.
        @(negedge clk);
        s1_req = 1'b1;
        wait_grant(who, waited);
        check("to_grant", 80'(who), 80'(1));
        hi = 0;
        while (s1_gnt && hi < 40) begin
            hi++;
            if (hi == 3) s0_req = 1'b1;
            @(negedge clk);
        end
        check("to_hold_cycles", 80'(hi), 80'(8));
        check("to_count", 80'(timeouts), 80'(1));
        wait_grant(who, waited);
        check("to_next_grant", 80'(who), 80'(0));
        check("to_gap", 80'(waited), 80'(2));
        s1_req = 1'b0;
        send_frame(0, 2);
        s0_req = 1'b0;
        check("to_s0_frames", 80'(s0_frames), 80'(2));

        // Reset mid-frame drops everything asynchronously.
        @(negedge clk);
        s0_req = 1'b1;
        wait_grant(who, waited);
        drive_src(0, 1'b1, 8'h00, 64'h0, 1'b0);
        @(negedge clk);
        drive_src(0, 1'b0, 8'hFF, 64'h21, 1'b0);
        @(negedge clk);
        drive_src(0, 1'b0, 8'hFF, 64'h22, 1'b0);
        tx_ack = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 80'({s0_gnt, s1_gnt, tx_start, tx_data_valid, tx_data,
                                        tx_underrun, s0_tx_ack, s1_tx_ack}), 80'(0));
        check("rst_async_counters", 80'({s0_frames, s1_frames, timeouts}), 80'(0));
        drive_src(0, 1'b0, 8'h00, 64'h0, 1'b0);
        tx_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both requesting: grants alternate starting with s0 after reset.
        s0_req = 1'b1;
        s1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(who, waited);
            check($sformatf("rr_order%0d", i), 80'(who), 80'(i % 2));
            check($sformatf("rr_gap%0d", i), 80'(waited), 80'((i == 0) ? 1 : 2));
            if (i == 5) begin
                s0_req = 1'b0;
                s1_req = 1'b0;
            end
            send_frame((who < 0) ? 0 : who, 3);
            check($sformatf("rr_release%0d", i), 80'({s0_gnt, s1_gnt}), 80'(0));
        end
        check("rr_frames", 80'({s0_frames, s1_frames}), 80'({2'd3, 2'd3}));

        // One more s0 frame wraps the 2-bit counter.
        @(negedge clk);
        s0_req = 1'b1;
        wait_grant(who, waited);
        check("wrap_grant", 80'(who), 80'(0));
        s0_req = 1'b0;
        send_frame(0, 2);
        check("wrap_frames", 80'({s0_frames, s1_frames}), 80'({2'd0, 2'd3}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
